// File: rtl/gc_pkg.sv
// Shared definitions for the GC/N64 line pulse transmitter.
// Holds the symbol codes, the transmit FSM state encoding and the phase
// lengths in microseconds that the pulse timer is scaled from.
package gc_pkg;

  // Line symbol codes as presented on sym_data.
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_RSVD = 2'b10;
  localparam logic [1:0] SYM_STOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } tx_state_e;

  // Phase lengths in microseconds: a data bit is one short and one long
  // phase, totalling one bit period.
  localparam int PH_SHORT_US = 1;
  localparam int PH_LONG_US  = 3;
  localparam int PH_BIT_US   = 4;

endpackage

// File: rtl/gc_sym_fifo.sv
// Purpose : small symbol queue between the handshake and the line FSM.
// Latency : a pushed entry is visible on pop_dat / empty one edge after the push.
// Backpr. : ready is a registered !full; flush empties the queue on the next edge.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop all entries (wins over push and pop)
//   push, push_dat    write one entry (ignored when not ready)
//   pop               consume the head entry (ignored when empty)
//   pop_dat           head entry, valid while !empty
//   empty, ready      queue empty / queue can accept
module gc_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // address plus wrap bit

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ready_q, ready_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign ready   = ready_q;
  assign push_ok = push && ready_q && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Full is decoded from the next pointers so ready can come from a flop.
    ready_d = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                (wr_ptr_d[AW] != rd_ptr_d[AW]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/gc_pulse_tx.sv
// Purpose : turns queued line symbols into GC/N64 data-line pulses.
// Latency : symbol pushed at edge T into an idle, empty block drives the line low after T+1.
// Backpr. : sym_ready is a registered !full of the symbol queue.
//
// Optional feature macro: GC_PULSE_ABORT_EN adds the abort input, which
// flushes the queue and releases the line on the next edge.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   sym_valid, sym_data    symbol offer (00 data 0, 01 data 1, 11 stop, 10 reserved)
//   sym_ready              queue can accept
//   pulse                  line drive, 1 = released/high
//   transmitting           high while a symbol is on the line
//   fifo_empty             queue empty
//   sym_err                sticky, a reserved code was accepted
//   abort                  (GC_PULSE_ABORT_EN only) flush and release
module gc_pulse_tx
  import gc_pkg::*;
#(
  parameter int CLK_PER_US  = 50,
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_LOW_US = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym_data,
  output logic       sym_ready,
  output logic       pulse,
  output logic       transmitting,
  output logic       fifo_empty,
  output logic       sym_err
`ifdef GC_PULSE_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int CNT_W = $clog2(PH_BIT_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] SHORT_LEN = CNT_W'(PH_SHORT_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] LONG_LEN  = CNT_W'(PH_LONG_US * CLK_PER_US);
  localparam logic [CNT_W-1:0] STOP_LEN  = CNT_W'(STOP_LOW_US * CLK_PER_US);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sym_q, sym_d;
  logic             pulse_q, pulse_d;
  logic             tx_q, tx_d;
  logic             err_q, err_d;

  logic             abort_i;
  logic             accept;
  logic             push;
  logic             pop;
  logic [1:0]       head_dat;
  logic             expire;

`ifdef GC_PULSE_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Reserved codes complete the handshake but never reach the queue.
  assign accept = sym_valid && sym_ready;
  assign push   = accept && (sym_data != SYM_RSVD) && !abort_i;
  assign err_d  = err_q || (accept && (sym_data == SYM_RSVD));
  assign expire = (cnt_q == CNT_W'(1));

  gc_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort_i),
    .push     (push),
    .push_dat (sym_data),
    .pop      (pop),
    .pop_dat  (head_dat),
    .empty    (fifo_empty),
    .ready    (sym_ready)
  );

  function automatic logic [CNT_W-1:0] low_len(input logic [1:0] code);
    case (code)
      SYM_ONE:  return SHORT_LEN;
      SYM_STOP: return STOP_LEN;
      default:  return LONG_LEN;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    pulse_d = pulse_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sym_d   = head_dat;
          cnt_d   = low_len(head_dat);
          pulse_d = 1'b0;
          tx_d    = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (expire) begin
          pulse_d = 1'b1;
          if (sym_q == SYM_STOP) begin
            tx_d    = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d   = (sym_q == SYM_ONE) ? LONG_LEN : SHORT_LEN;
            state_d = HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (expire) begin
          // Chain straight into the next symbol so bits stay one period apart.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sym_d   = head_dat;
            cnt_d   = low_len(head_dat);
            pulse_d = 1'b0;
            state_d = LOW;
          end else begin
            tx_d    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        pulse_d = 1'b1;
        tx_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      pop     = 1'b0;
      pulse_d = 1'b1;
      tx_d    = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sym_q   <= SYM_ZERO;
      pulse_q <= 1'b1;
      tx_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      pulse_q <= pulse_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
    end
  end

  assign pulse        = pulse_q;
  assign transmitting = tx_q;
  assign sym_err      = err_q;

endmodule

// File: tb/tb_gc_pulse_tx.sv
module tb_gc_pulse_tx;

  localparam int U       = 4;
  localparam int DEPTH   = 4;
  localparam int STOP_US = 1;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_ready;
  logic       pulse;
  logic       transmitting;
  logic       fifo_empty;
  logic       sym_err;
  logic       abort;

  int n_checks = 0;
  int n_fail   = 0;
  int first_stall;

  logic [1:0] stim_q[$];
  bit         exp_p[$];
  bit         exp_t[$];

  gc_pulse_tx #(
    .CLK_PER_US  (U),
    .FIFO_DEPTH  (DEPTH),
    .STOP_LOW_US (STOP_US)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .sym_ready    (sym_ready),
    .pulse        (pulse),
    .transmitting (transmitting),
    .fifo_empty   (fifo_empty),
    .sym_err      (sym_err)
`ifdef GC_PULSE_ABORT_EN
    ,
    .abort        (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line waveform, one entry per clock, for the queued symbols
  // when the first one is accepted into an idle block. Index 0 is the
  // cycle right after the accepting edge.
  function automatic void build_expected();
    bit after_stop;
    int lo, hi;
    exp_p.delete();
    exp_t.delete();
    exp_p.push_back(1'b1);
    exp_t.push_back(1'b0);
    after_stop = 1'b0;
    foreach (stim_q[i]) begin
      if (stim_q[i] == 2'b10) continue;
      case (stim_q[i])
        2'b01:   begin lo = U;           hi = 3 * U; end
        2'b00:   begin lo = 3 * U;       hi = U;     end
        default: begin lo = STOP_US * U; hi = 0;     end
      endcase
      // A stop returns to idle, costing one released cycle before the next pop.
      if (after_stop) begin
        exp_p.push_back(1'b1);
        exp_t.push_back(1'b0);
      end
      repeat (lo) begin exp_p.push_back(1'b0); exp_t.push_back(1'b1); end
      repeat (hi) begin exp_p.push_back(1'b1); exp_t.push_back(1'b1); end
      after_stop = (stim_q[i] == 2'b11);
    end
    repeat (6) begin exp_p.push_back(1'b1); exp_t.push_back(1'b0); end
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym_data  = 2'b00;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Push stim_q with a held-valid handshake while checking the line cycle by cycle.
  task automatic run_stream(input string tag);
    build_expected();
    first_stall = -1;
    @(negedge clk);
    fork
      begin
        int i = 0;
        int guard = 0;
        while (i < stim_q.size() && guard < 4000) begin
          sym_valid = 1'b1;
          sym_data  = stim_q[i];
          if (sym_ready) i++;
          else if (first_stall < 0) first_stall = i;
          @(negedge clk);
          guard++;
        end
        sym_valid = 1'b0;
        n_checks++;
        if (i != stim_q.size()) begin
          n_fail++;
          $display("FAIL %s push_timeout: pushed=%0d required=%0d", tag, i, stim_q.size());
        end
      end
      begin
        @(posedge clk);
        for (int k = 0; k < exp_p.size(); k++) begin
          @(negedge clk);
          n_checks++;
          if (pulse !== exp_p[k] || transmitting !== exp_t[k]) begin
            n_fail++;
            $display("FAIL %s wave[%0d]: pulse=%b tx=%b required pulse=%b tx=%b",
                     tag, k, pulse, transmitting, exp_p[k], exp_t[k]);
          end
        end
      end
    join
    n_checks++;
    if (fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s drained: fifo_empty=%b required 1", tag, fifo_empty);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym_data  = 2'b00;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pulse, transmitting, sym_ready, fifo_empty, sym_err} !== 5'b10110) begin
      n_fail++;
      $display("FAIL reset_state: p/tx/rdy/empty/err=%b required 10110",
               {pulse, transmitting, sym_ready, fifo_empty, sym_err});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pulse, transmitting, sym_ready, fifo_empty, sym_err} !== 5'b10110) begin
      n_fail++;
      $display("FAIL idle_after_reset: p/tx/rdy/empty/err=%b required 10110",
               {pulse, transmitting, sym_ready, fifo_empty, sym_err});
    end
  endtask

  task automatic test_single_one();
    stim_q = '{2'b01};
    run_stream("single_one");
  endtask

  task automatic test_back_to_back();
    stim_q = '{2'b00, 2'b01, 2'b11};
    run_stream("b2b_zero_one_stop");
  endtask

  task automatic test_fill();
    stim_q = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    run_stream("fill");
    n_checks++;
    if (first_stall !== DEPTH + 1) begin
      n_fail++;
      $display("FAIL fill_ready: first stall after %0d accepts, required %0d",
               first_stall, DEPTH + 1);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(3, 9);
      stim_q.delete();
      for (int i = 0; i < n; i++) begin
        int c;
        c = $urandom_range(0, 2);
        stim_q.push_back(c == 2 ? 2'b11 : 2'(c));
      end
      run_stream($sformatf("random%0d", r));
    end
  endtask

  task automatic test_reserved();
    stim_q = '{2'b10};
    run_stream("rsvd_only");
    n_checks++;
    if (sym_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rsvd_err_set: sym_err=%b required 1", sym_err);
    end
    stim_q = '{2'b01, 2'b10, 2'b00};
    run_stream("rsvd_mixed");
    n_checks++;
    if (sym_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rsvd_err_sticky: sym_err=%b required 1", sym_err);
    end
    do_reset();
    n_checks++;
    if (sym_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rsvd_err_cleared: sym_err=%b required 0", sym_err);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    sym_valid = 1'b1;
    sym_data  = 2'b00;
    @(negedge clk);
    sym_data  = 2'b00;
    @(negedge clk);
    sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pulse !== 1'b0 || transmitting !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_low_phase: pulse=%b tx=%b required 0 1", pulse, transmitting);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pulse, transmitting, sym_ready, fifo_empty} !== 4'b1011) begin
      n_fail++;
      $display("FAIL reset_mid_symbol: p/tx/rdy/empty=%b required 1011",
               {pulse, transmitting, sym_ready, fifo_empty});
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pulse !== 1'b1 || transmitting !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset, required 0", bad);
    end
  endtask

`ifdef GC_PULSE_ABORT_EN
  task automatic test_abort();
    int bad;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sym_valid = 1'b1;
      sym_data  = 2'b01;
      @(negedge clk);
    end
    sym_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (pulse !== 1'b1 || transmitting !== 1'b1 || fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre_high: pulse=%b tx=%b empty=%b required 1 1 0",
               pulse, transmitting, fifo_empty);
    end
    abort     = 1'b1;
    sym_valid = 1'b1;
    sym_data  = 2'b00;
    @(negedge clk);
    abort     = 1'b0;
    sym_valid = 1'b0;
    n_checks++;
    if ({pulse, transmitting, fifo_empty, sym_ready} !== 4'b1011) begin
      n_fail++;
      $display("FAIL abort_flush: p/tx/empty/rdy=%b required 1011",
               {pulse, transmitting, fifo_empty, sym_ready});
    end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (pulse !== 1'b1 || transmitting !== 1'b0 || fifo_empty !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_one();
    test_back_to_back();
    test_fill();
    test_random();
    test_reserved();
    test_reset_mid();
`ifdef GC_PULSE_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
